map_access_arbiter: RTL and testbench
=====================================

// Module: map_access_arbiter
// PURPOSE
//  Shares the single read/write port of the tile-map RAM (30 rows x 160-bit words, 40 tiles x 4 b) among NREQ requesters.
//  Requesters are pacman collision lookup, ghost AI lookups and the score logic. Each request is a lookup or a
//  lookup-and-clear, and the block runs the RAM read-modify-write sequence. Sits between requesters and map RAM port A.
// PARAMETERS
//  NREQ      3    number of requesters (2..8); index 0 = pacman
//  ROWS      30   valid map rows; row >= ROWS is out of range
//  COLS      40   valid map columns; col >= COLS is out of range
// PORTS
//  CLOCK_50     in   1           system clock; all logic on posedge
//  reset        in   1           synchronous, active-low reset
//  init_busy    in   1           map RAM re-init copy in progress; no new grants while 1
//  req          in   NREQ        request per requester; held until its response
//  req_clr      in   NREQ        1 = clear the tile after reading if it is DOT or PILL
//  req_row      in   NREQ*5      row address per requester
//  req_col      in   NREQ*6      column address per requester
//  gnt          out  NREQ        one-hot, 1-cycle pulse when a request is accepted
//  rsp_valid    out  1           1-cycle pulse: lookup complete
//  rsp_id       out  $clog2(NREQ) requester index of the response
//  rsp_tile     out  4           tile code read (value before any clear)
//  ram_addr     out  5           map RAM address
//  ram_wdata    out  160         map RAM write word
//  ram_wren     out  1           map RAM write enable
//  ram_q        in   160         map RAM read word; 1-cycle registered read latency
//  dots_cleared out  16          count of DOT tiles cleared; saturates at 16'hFFFF
//  busy         out  1           FSM not in S_IDLE
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - FSM -> S_IDLE; RR pointer -> 0; dots_cleared -> 0.
//   - gnt, rsp_valid, ram_wren -> 0; rsp_id, rsp_tile, ram_addr, ram_wdata -> 0.
//   - A reset mid-sequence aborts it: no write is issued and no response is given.
//  Tile nibble for column c is ram_q[159-(4*c+3) +: 4]; column 0 is the MSB nibble.
//  Tile codes: 0 EMPTY, 1 WALL, 2 DOT, 3 PILL.
//  FSM:
//   - S_IDLE: if init_busy==0 and |req, pick a winner, latch row/col/clr/id, pulse gnt[winner].
//     - Out-of-range row/col: go to S_RESP with tile=WALL; no RAM access.
//     - Otherwise go to S_READ.
//   - S_READ: ram_addr=row, ram_wren=0 -> S_CAPT.
//   - S_CAPT: latch the ram_q word and its tile.
//     - clr==1 and tile is DOT or PILL: go to S_WRITE.
//     - Otherwise go to S_RESP.
//   - S_WRITE: ram_addr=row, ram_wdata = latched word with the tile nibble zeroed, ram_wren=1 for exactly 1 cycle.
//     - dots_cleared increments if tile was DOT.
//     - -> S_RESP.
//   - S_RESP: rsp_valid=1, rsp_id, rsp_tile=original tile -> S_IDLE.
//  Latency (gnt cycle = 0): rsp_valid at cycle 3 for a read, cycle 4 for a read+clear, cycle 1 for out-of-range.
//  Throughput: one request in flight; a new grant at the earliest in the cycle after rsp_valid.
//  Handshake:
//   - The requester holds req/addr/clr stable until it sees rsp_valid with its rsp_id.
//   - It drops req in the next cycle, otherwise it is re-arbitrated.
//   - Changes to a granted requester's inputs after gnt are ignored (values are latched).
//  Arbitration: round-robin from pointer; pointer <- winner+1 (mod NREQ) on each grant.
//  Simultaneous events:
//   - init_busy rising mid-sequence does not abort the sequence; it only blocks the next grant.
//   - The dots_cleared increment and saturation occur in the same cycle.
// CONFIGURATION
//  MAP_ARB_PRIO_EN defined:
//   - requester 0 (pacman) wins whenever req[0]=1, ignoring the pointer.
//   - Others use round-robin among themselves; the pointer is not advanced by a req-0 grant.
//  MAP_ARB_PRIO_EN undefined: pure round-robin over all NREQ requesters.
// STRUCTURE
//  Package map_arb_pkg:
//   - tile_t enum (EMPTY, WALL, DOT, PILL);
//   - constants MAP_ROWS=30, MAP_COLS=40, TILE_W=4, WORD_W=160;
//   - arb_state_t enum {S_IDLE, S_READ, S_CAPT, S_WRITE, S_RESP}.
//  Sub-module rr_arbiter: NREQ req, pointer, prio-enable -> one-hot grant plus winner index; purely combinational.
// TESTING
//  1 Reset: reset=0 two cycles -> all outputs 0, busy=0; row 3 col 5 preloaded DOT, unchanged.
//  2 Read: req[1], row 3, col 5 (DOT), clr=0 -> gnt[1] at t0; rsp_valid at t3, rsp_id=1, rsp_tile=2; ram_wren never 1.
//  3 Clear: req[0], row 3, col 5 (DOT), clr=1 -> write at t3, nibble 0 in word; rsp_tile=2 at t4; dots_cleared=1.
//     Repeating the request gives rsp_tile=0 and no write.
//  4 Fairness: req=3'b111 held, no prio -> grant order 0,1,2,0.
//     With MAP_ARB_PRIO_EN -> order 0,0,0 while req[0] is held.
//  5 Out-of-range: row 30 or col 40 -> rsp_valid at t1, rsp_tile=1, no RAM access.
//     With init_busy=1 and req pending -> no gnt until init_busy=0.
//  6 Mid-op reset: reset=0 during S_WRITE-bound sequence (cycle t2) -> no ram_wren, no rsp_valid, FSM in S_IDLE.

Source files
------------

// File: rtl/map_arb_pkg.sv
// rtl/map_arb_pkg.sv - shared types, map geometry and tile nibble helpers for the map access arbiter
package map_arb_pkg;

    localparam int MAP_ROWS = 30;
    localparam int MAP_COLS = 40;
    localparam int TILE_W   = 4;
    localparam int WORD_W   = 160;

    typedef enum logic [3:0] {
        EMPTY = 4'd0,
        WALL  = 4'd1,
        DOT   = 4'd2,
        PILL  = 4'd3
    } tile_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_WRITE,
        S_RESP
    } arb_state_t;

    // Column 0 sits in the most significant nibble, so shift the wanted nibble up to the top.
    function automatic logic [TILE_W-1:0] tile_of(input logic [WORD_W-1:0] word, input logic [5:0] col);
        logic [WORD_W-1:0] sh;
        sh = word << {col, 2'b00};
        return sh[WORD_W-1 -: TILE_W];
    endfunction

    // Zero the nibble of one column, leaving the rest of the row word intact.
    function automatic logic [WORD_W-1:0] clear_tile(input logic [WORD_W-1:0] word, input logic [5:0] col);
        logic [WORD_W-1:0] mask;
        mask = {{TILE_W{1'b1}}, {(WORD_W-TILE_W){1'b0}}} >> {col, 2'b00};
        return word & ~mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with optional requester-0 priority
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            prio_en,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   win
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic              found;
    int                off;
    int                win_i;

    // Rotate requests so the pointer position is bit 0, take the first set bit, map back.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NREQ-1:0];
        found = 1'b0;
        off   = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = j;
            end
        end
        win_i = int'(ptr) + off;
        if (win_i >= NREQ) begin
            win_i = win_i - NREQ;
        end
        win = win_i[PW-1:0];
        gnt = found ? (NREQ'(1) << win) : '0;
        if (prio_en && req[0]) begin
            win = '0;
            gnt = NREQ'(1);
        end
    end

endmodule

// File: rtl/map_access_arbiter.sv
// rtl/map_access_arbiter.sv - tile-map RAM port arbiter with read/clear sequencing (option: MAP_ARB_PRIO_EN)
module map_access_arbiter
    import map_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int ROWS = MAP_ROWS,
    parameter int COLS = MAP_COLS
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     init_busy,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_clr,
    input  logic [NREQ*5-1:0]        req_row,
    input  logic [NREQ*6-1:0]        req_col,
    output logic [NREQ-1:0]          gnt,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [3:0]               rsp_tile,
    output logic [4:0]               ram_addr,
    output logic [WORD_W-1:0]        ram_wdata,
    output logic                     ram_wren,
    input  logic [WORD_W-1:0]        ram_q,
    output logic [15:0]              dots_cleared,
    output logic                     busy
);

    localparam int PW = $clog2(NREQ);

`ifdef MAP_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    arb_state_t          state_q, state_d;
    logic [PW-1:0]       ptr_q;
    logic [4:0]          row_q;
    logic [5:0]          col_q;
    logic                clr_q;
    logic [PW-1:0]       id_q;
    logic [WORD_W-1:0]   word_q;
    logic [3:0]          tile_q;

    logic [NREQ-1:0]     arb_gnt;
    logic [PW-1:0]       arb_win;
    logic [NREQ*5-1:0]   row_sh;
    logic [NREQ*6-1:0]   col_sh;
    logic [4:0]          sel_row;
    logic [5:0]          sel_col;
    logic                sel_clr;
    logic                sel_oor;
    logic                accept;
    logic [3:0]          cap_tile;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .prio_en (PRIO_EN),
        .gnt     (arb_gnt),
        .win     (arb_win)
    );

    // Pick the winner's address fields and decide the next step of the read-modify-write sequence.
    always_comb begin
        row_sh    = req_row >> (int'(arb_win) * 5);
        col_sh    = req_col >> (int'(arb_win) * 6);
        sel_row   = row_sh[4:0];
        sel_col   = col_sh[5:0];
        sel_clr   = req_clr[arb_win];
        sel_oor   = (int'(sel_row) >= ROWS) || (int'(sel_col) >= COLS);
        cap_tile  = tile_of(ram_q, col_q);
        state_d   = state_q;
        accept    = 1'b0;
        gnt       = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wren  = 1'b0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_tile  = '0;
        case (state_q)
            S_IDLE: begin
                if (reset && !init_busy && (|req)) begin
                    accept  = 1'b1;
                    gnt     = arb_gnt;
                    state_d = sel_oor ? S_RESP : S_READ;
                end
            end
            S_READ: begin
                ram_addr = row_q;
                state_d  = S_CAPT;
            end
            S_CAPT: begin
                if (clr_q && (cap_tile == DOT || cap_tile == PILL)) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                ram_addr  = row_q;
                ram_wdata = clear_tile(word_q, col_q);
                ram_wren  = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_tile  = tile_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, request latches, round-robin pointer and the cleared-dot counter.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            clr_q        <= 1'b0;
            id_q         <= '0;
            word_q       <= '0;
            tile_q       <= '0;
            dots_cleared <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                row_q  <= sel_row;
                col_q  <= sel_col;
                clr_q  <= sel_clr;
                id_q   <= arb_win;
                tile_q <= WALL;
                // A priority grant to requester 0 leaves the rotation of the others untouched.
                if (!(PRIO_EN && req[0])) begin
                    ptr_q <= (arb_win == PW'(NREQ-1)) ? '0 : arb_win + 1'b1;
                end
            end
            if (state_q == S_CAPT) begin
                word_q <= ram_q;
                tile_q <= cap_tile;
            end
            if (state_q == S_WRITE && tile_q == DOT && dots_cleared != 16'hFFFF) begin
                dots_cleared <= dots_cleared + 16'd1;
            end
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_map_access_arbiter.sv
// tb/tb_map_access_arbiter.sv - directed scoreboard bench for map_access_arbiter
module tb_map_access_arbiter;
    import map_arb_pkg::*;

    logic         CLOCK_50 = 1'b0;
    logic         reset = 1'b0;
    logic         init_busy = 1'b0;
    logic [2:0]   req = '0;
    logic [2:0]   req_clr = '0;
    logic [4:0]   rows [3];
    logic [5:0]   cols [3];
    logic [14:0]  req_row;
    logic [17:0]  req_col;
    logic [2:0]   gnt;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [3:0]   rsp_tile;
    logic [4:0]   ram_addr;
    logic [159:0] ram_wdata;
    logic         ram_wren;
    logic [159:0] ram_q = '0;
    logic [15:0]  dots_cleared;
    logic         busy;

    assign req_row = {rows[2], rows[1], rows[0]};
    assign req_col = {cols[2], cols[1], cols[0]};

    map_access_arbiter #(.NREQ(3)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .init_busy    (init_busy),
        .req          (req),
        .req_clr      (req_clr),
        .req_row      (req_row),
        .req_col      (req_col),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_tile     (rsp_tile),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .dots_cleared (dots_cleared),
        .busy         (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [159:0] mem [0:31];
    always @(posedge CLOCK_50) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [159:0] put(input logic [159:0] w, input int col, input logic [3:0] v);
        logic [159:0] m;
        logic [159:0] d;
        m = 160'hF;
        m = m << (156 - 4 * col);
        d = {156'b0, v};
        d = d << (156 - 4 * col);
        return (w & ~m) | d;
    endfunction

    typedef struct { int id; int tile; } exp_t;
    exp_t sb[$];

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int gnt_cnt = 0, rsp_cnt = 0, wr_cnt = 0;
    int gnt_cyc = 0, rsp_cyc = 0;
    logic [2:0] last_gnt = '0;
    int gnt_order[$];
    logic [159:0] last_wdata = '0;
    logic [4:0] last_waddr = '0;

    always @(negedge CLOCK_50) begin
        exp_t e;
        if (|gnt) begin
            gnt_cnt++;
            gnt_cyc = cyc;
            last_gnt = gnt;
            for (int i = 0; i < 3; i++) if (gnt[i]) gnt_order.push_back(i);
        end
        if (ram_wren) begin
            wr_cnt++;
            last_wdata = ram_wdata;
            last_waddr = ram_addr;
        end
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                $error("FAIL unexpected_rsp: observed id %0d tile %0d expected no response", rsp_id, rsp_tile);
            end else begin
                e = sb.pop_front();
                check("rsp_id", rsp_id, e.id);
                check("rsp_tile", rsp_tile, e.tile);
            end
        end
    end

    task automatic do_req(input int id, input int row, input int col, input bit clr,
                          input int exp_tile, input int exp_lat, input int exp_wr, input int busy_cyc);
        int r0, w0, g0;
        bit got;
        sb.push_back('{id, exp_tile});
        r0 = rsp_cnt;
        w0 = wr_cnt;
        @(posedge CLOCK_50); #1;
        if (busy_cyc > 0) init_busy = 1'b1;
        rows[id] = 5'(row);
        cols[id] = 6'(col);
        req_clr[id] = clr;
        req[id] = 1'b1;
        if (busy_cyc > 0) begin
            g0 = gnt_cnt;
            repeat (busy_cyc) begin @(posedge CLOCK_50); #1; end
            check("init_busy_no_gnt", gnt_cnt - g0, 0);
            init_busy = 1'b0;
        end
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(posedge CLOCK_50); #1;
            got = (rsp_cnt != r0);
        end
        req[id] = 1'b0;
        check($sformatf("rsp_seen_req%0d", id), got, 1);
        check("gnt_onehot", last_gnt, 3'b001 << id);
        check("latency", rsp_cyc - gnt_cyc, exp_lat);
        check("write_count", wr_cnt - w0, exp_wr);
    endtask

    initial begin
        logic [159:0] w3, w3c, w7, w7c, w29;
        int r0, w0, g0, nord;
        bit got;
        int exp_ord[4];

        w3  = put(put(put('0, 4, 4'd1), 5, 4'd2), 6, 4'd3);
        w3c = put(put('0, 4, 4'd1), 6, 4'd3);
        w7  = put(put('0, 38, 4'd2), 39, 4'd3);
        w7c = put('0, 38, 4'd2);
        w29 = put('0, 39, 4'd3);
        for (int r = 0; r < 32; r++) mem[r] = '0;
        mem[3] = w3;
        mem[7] = w7;
        mem[29] = w29;
        for (int i = 0; i < 3; i++) begin rows[i] = '0; cols[i] = '0; end

        // reset
        reset = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("rst_ctrl", {gnt, rsp_valid, ram_wren, rsp_id, rsp_tile, ram_addr}, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_dots", dots_cleared, 0);
        check("rst_busy", busy, 0);
        check("rst_mem3", mem[3], w3);
        reset = 1'b1;

        // plain read and read-with-clear
        do_req(1, 3, 5, 1'b0, 2, 3, 0, 0);
        do_req(0, 3, 5, 1'b1, 2, 4, 1, 0);
        check("clr_waddr", last_waddr, 3);
        check("clr_wdata", last_wdata, w3c);
        check("clr_dots", dots_cleared, 1);
        check("clr_mem3", mem[3], w3c);
        do_req(0, 3, 5, 1'b1, 0, 3, 0, 0);
        check("reclr_dots", dots_cleared, 1);
        do_req(2, 7, 39, 1'b1, 3, 4, 1, 0);
        check("pill_wdata", last_wdata, w7c);
        check("pill_dots", dots_cleared, 1);
        do_req(1, 29, 39, 1'b0, 3, 3, 0, 0);

        // out of range, then init_busy blocking
        do_req(1, 30, 0, 1'b0, 1, 1, 0, 0);
        do_req(2, 0, 40, 1'b1, 1, 1, 0, 0);
        do_req(0, 7, 38, 1'b0, 2, 3, 0, 5);

        // reset during a clear sequence, asserted in the capture cycle
        r0 = rsp_cnt; w0 = wr_cnt; g0 = gnt_cnt;
        @(posedge CLOCK_50); #1;
        rows[0] = 5'd7; cols[0] = 6'd38; req_clr[0] = 1'b1; req[0] = 1'b1;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50); #1;
        check("midop_busy_t2", busy, 1);
        reset = 1'b0;
        req = '0;
        @(posedge CLOCK_50); #1;
        check("midop_idle", {busy, ram_wren, rsp_valid}, 0);
        reset = 1'b1;
        repeat (6) @(posedge CLOCK_50);
        #1;
        check("midop_gnt", gnt_cnt - g0, 1);
        check("midop_no_rsp", rsp_cnt - r0, 0);
        check("midop_no_wr", wr_cnt - w0, 0);
        check("midop_mem7", mem[7], w7c);
        check("midop_dots", dots_cleared, 0);

        // fairness with all three requesting continuously
`ifdef MAP_ARB_PRIO_EN
        nord = 3;
        exp_ord = '{0, 0, 0, 0};
`else
        nord = 4;
        exp_ord = '{0, 1, 2, 0};
`endif
        gnt_order.delete();
        for (int i = 0; i < nord; i++) sb.push_back('{exp_ord[i], 0});
        r0 = rsp_cnt;
        @(posedge CLOCK_50); #1;
        for (int i = 0; i < 3; i++) begin rows[i] = 5'd3; cols[i] = 6'd5; end
        req_clr = '0;
        req = 3'b111;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(posedge CLOCK_50); #1;
            got = (rsp_cnt - r0 == nord);
        end
        req = '0;
        check("fair_done", got, 1);
        check("fair_gnt_count", gnt_order.size(), nord);
        for (int i = 0; i < nord && i < gnt_order.size(); i++)
            check($sformatf("fair_order_%0d", i), gnt_order[i], exp_ord[i]);

        repeat (3) @(posedge CLOCK_50);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
